// File: rtl/flp_unpack_reg_if.sv
// Bus bundle for the FP field unpacker: packed word in, decoded fields and flags out.
interface flp_unpack_reg_if #(
  parameter int unsigned EWIDTH = 8,
  parameter int unsigned SWIDTH = 23
);
  localparam int unsigned W = 1 + EWIDTH + SWIDTH;

  logic              i_valid;
  logic [W-1:0]      i_fpd;
  logic              o_valid;
  logic              o_sn;
  logic [EWIDTH-1:0] o_ex;
  logic [SWIDTH:0]   o_sg;
  logic              o_zero;
  logic              o_nan;
  logic              o_inf;

  // Producer side: drives the packed word, observes decoded results.
  modport master (
    output i_valid, i_fpd,
    input  o_valid, o_sn, o_ex, o_sg, o_zero, o_nan, o_inf
  );

  // Unpacker side.
  modport slave (
    input  i_valid, i_fpd,
    output o_valid, o_sn, o_ex, o_sg, o_zero, o_nan, o_inf
  );
endinterface

// File: rtl/flp_unpack_reg.sv
// Registered IEEE-754-style field unpacker: sign, biased exponent, significand
// with hidden bit restored, plus zero/NaN/infinity flags. One cycle latency.
// Optional macro FLP_UNPACK_DENORM_EN keeps denormals (effective exponent 1,
// hidden bit 0) instead of flushing them to zero.
module flp_unpack_reg #(
  parameter int unsigned EWIDTH = 8,
  parameter int unsigned SWIDTH = 23
) (
  input logic             clk,
  input logic             rst,
  flp_unpack_reg_if.slave bus
);
  localparam int unsigned W = 1 + EWIDTH + SWIDTH;

  logic [EWIDTH-1:0] e_c;
  logic [SWIDTH-1:0] f_c;
  logic              e_max_c;
  logic              f_nz_c;
  logic [EWIDTH-1:0] ex_c;
  logic [SWIDTH:0]   sg_c;
  logic              zero_c;
  logic              nan_c;
  logic              inf_c;

  // Field decode of the incoming word.
  always_comb begin
    e_c     = bus.i_fpd[W-2:SWIDTH];
    f_c     = bus.i_fpd[SWIDTH-1:0];
    e_max_c = &e_c;
    f_nz_c  = |f_c;
    ex_c    = e_c;
    sg_c    = {1'b1, f_c};
    zero_c  = 1'b0;
    nan_c   = e_max_c & f_nz_c;
    inf_c   = e_max_c & ~f_nz_c;
    if (e_c == '0) begin
`ifdef FLP_UNPACK_DENORM_EN
      if (f_nz_c) begin
        ex_c = EWIDTH'(1);
        sg_c = {1'b0, f_c};
      end else begin
        ex_c   = '0;
        sg_c   = '0;
        zero_c = 1'b1;
      end
`else
      ex_c   = '0;
      sg_c   = '0;
      zero_c = 1'b1;
`endif
    end
  end

  // Output registers: valid tracks input every cycle, data loads only on valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_sn    <= 1'b0;
      bus.o_ex    <= '0;
      bus.o_sg    <= '0;
      bus.o_zero  <= 1'b0;
      bus.o_nan   <= 1'b0;
      bus.o_inf   <= 1'b0;
    end else begin
      bus.o_valid <= bus.i_valid;
      if (bus.i_valid) begin
        bus.o_sn   <= bus.i_fpd[W-1];
        bus.o_ex   <= ex_c;
        bus.o_sg   <= sg_c;
        bus.o_zero <= zero_c;
        bus.o_nan  <= nan_c;
        bus.o_inf  <= inf_c;
      end
    end
  end
endmodule

// File: tb/tb_flp_unpack_reg.sv
// Bench for flp_unpack_reg (FP32 configuration): directed test-plan words,
// then randomized words/valid/reset against an arithmetic reference model.
module tb_flp_unpack_reg;
  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  logic        exp_valid, exp_sn, exp_zero, exp_nan, exp_inf;
  logic [7:0]  exp_ex;
  logic [23:0] exp_sg;

  flp_unpack_reg_if #(.EWIDTH(8), .SWIDTH(23)) bus ();

  flp_unpack_reg #(.EWIDTH(8), .SWIDTH(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode computed from the numeric fields of a 32-bit word.
  function automatic void model(input logic [31:0] w, output logic sn, output logic [7:0] ex,
                                output logic [23:0] sg, output logic z, output logic n,
                                output logic i);
    int unsigned e;
    int unsigned f;
    e  = (w >> 23) & 32'd255;
    f  = w & 32'h007F_FFFF;
    sn = w[31];
    z  = 1'b0;
    n  = 1'b0;
    i  = 1'b0;
    if (e == 0) begin
`ifdef FLP_UNPACK_DENORM_EN
      if (f != 0) begin
        ex = 8'd1;
        sg = 24'(f);
      end else begin
        ex = 8'd0;
        sg = 24'd0;
        z  = 1'b1;
      end
`else
      ex = 8'd0;
      sg = 24'd0;
      z  = 1'b1;
`endif
    end else begin
      ex = 8'(e);
      sg = 24'(32'h0080_0000 + f);
      if (e == 255) begin
        if (f == 0) i = 1'b1;
        else        n = 1'b1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare every output.
  task automatic step(input logic r, input logic v, input logic [31:0] w);
    @(negedge clk);
    rst         = r;
    bus.i_valid = v;
    bus.i_fpd   = w;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid = 1'b0; exp_sn = 1'b0; exp_ex = 8'd0; exp_sg = 24'd0;
      exp_zero = 1'b0; exp_nan = 1'b0; exp_inf = 1'b0;
    end else begin
      exp_valid = v;
      if (v) model(w, exp_sn, exp_ex, exp_sg, exp_zero, exp_nan, exp_inf);
    end
    check("o_valid", 32'(bus.o_valid), 32'(exp_valid));
    check("o_sn",    32'(bus.o_sn),    32'(exp_sn));
    check("o_ex",    32'(bus.o_ex),    32'(exp_ex));
    check("o_sg",    32'(bus.o_sg),    32'(exp_sg));
    check("o_zero",  32'(bus.o_zero),  32'(exp_zero));
    check("o_nan",   32'(bus.o_nan),   32'(exp_nan));
    check("o_inf",   32'(bus.o_inf),   32'(exp_inf));
    check("flags_onehot0", 32'($onehot0({bus.o_zero, bus.o_nan, bus.o_inf})), 32'd1);
  endtask

  initial begin
    logic        r;
    logic        v;
    logic [31:0] w;
    logic [7:0]  e;
    logic [22:0] f;
    vecs = 0;
    errs = 0;
    exp_valid = 1'b0; exp_sn = 1'b0; exp_ex = 8'd0; exp_sg = 24'd0;
    exp_zero = 1'b0; exp_nan = 1'b0; exp_inf = 1'b0;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_fpd   = '0;

    // Reset with valid asserted: reset wins.
    step(1'b1, 1'b1, 32'h3F80_0000);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);

    // Directed test-plan words with literal expectations.
    step(1'b0, 1'b1, 32'h0000_0000);
    check("zero_lit_zero", 32'(bus.o_zero), 32'd1);
    check("zero_lit_sg",   32'(bus.o_sg),   32'h0000_0000);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("nan_lit_sg",  32'(bus.o_sg),  32'h00FF_FFFF);
    check("nan_lit_nan", 32'(bus.o_nan), 32'd1);
    step(1'b0, 1'b1, 32'h7F80_0000);
    check("pinf_lit_sg", 32'(bus.o_sg), 32'h0080_0000);
    step(1'b0, 1'b1, 32'hFF80_0000);
    check("ninf_lit_sn",  32'(bus.o_sn),  32'd1);
    check("ninf_lit_inf", 32'(bus.o_inf), 32'd1);
    step(1'b0, 1'b1, 32'h0000_FFFF);
`ifdef FLP_UNPACK_DENORM_EN
    check("denorm_lit_zero", 32'(bus.o_zero), 32'd0);
    check("denorm_lit_sg",   32'(bus.o_sg),   32'h0000_FFFF);
    check("denorm_lit_ex",   32'(bus.o_ex),   32'h0000_0001);
`else
    check("denorm_lit_zero", 32'(bus.o_zero), 32'd1);
    check("denorm_lit_sg",   32'(bus.o_sg),   32'h0000_0000);
    check("denorm_lit_ex",   32'(bus.o_ex),   32'h0000_0000);
`endif
    step(1'b0, 1'b1, 32'hFF00_FFFF);
    check("norm_lit_ex", 32'(bus.o_ex), 32'h0000_00FE);
    check("norm_lit_sg", 32'(bus.o_sg), 32'h0080_FFFF);
    step(1'b0, 1'b1, 32'h7F00_FFFF);
    check("norm2_lit_sn", 32'(bus.o_sn), 32'd0);
    // Idle cycles: data holds, valid drops.
    step(1'b0, 1'b0, 32'h0000_0000);
    step(1'b0, 1'b0, 32'hFFFF_FFFF);
    check("hold_lit_ex", 32'(bus.o_ex), 32'h0000_00FE);
    check("hold_lit_sg", 32'(bus.o_sg), 32'h0080_FFFF);
    // Mid-stream reset discards the in-flight word.
    step(1'b0, 1'b1, 32'hC040_0000);
    step(1'b1, 1'b1, 32'h7FC0_0001);
    step(1'b0, 1'b0, 32'h1234_5678);

    // Randomized words biased toward the exponent corner cases.
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       e = 8'd0;
        1:       e = 8'hFF;
        2:       e = 8'($urandom_range(1, 2) == 1 ? 1 : 254);
        default: e = 8'($urandom);
      endcase
      f = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
      w = {1'($urandom), e, f};
      step(r, v, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
